// File: rtl/axis_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one 64-bit AXI-Stream TX path among NUM_SRC sources.
// A granted frame passes unbroken through its tlast beat, then GAP_CYC idle cycles precede the next grant.
module axis_tx_pkt_arbiter #(
    parameter  int NUM_SRC = 2,
    parameter  int GAP_CYC = 2,
    localparam int GID_W   = $clog2(NUM_SRC)
) (
    input  logic                   tx_clk_out,
    input  logic                   sys_rst,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid,
    input  logic [NUM_SRC*64-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*8-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]     s_axis_tlast,
    output logic [NUM_SRC-1:0]     s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   keep_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [GID_W-1:0] r_last_gnt, w_last_gnt_nxt;
    logic [GID_W-1:0] r_grant_id, w_grant_id_nxt;
    logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic             r_keep_err, w_keep_err_nxt;

    logic             w_found;
    logic [GID_W-1:0] w_sel;
    logic             w_src_valid;
    logic             w_src_last;
    logic [63:0]      w_src_data;
    logic [7:0]       w_src_keep;
    logic             w_beat;

    function automatic logic keep_is_tail(input logic [7:0] keep);
        case (keep)
            8'h01, 8'h03, 8'h07, 8'h0F,
            8'h1F, 8'h3F, 8'h7F, 8'hFF: keep_is_tail = 1'b1;
            default:                    keep_is_tail = 1'b0;
        endcase
    endfunction

    // Round-robin search: first requester found upward from the slot after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_gnt;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_found && s_axis_tvalid[i] &&
                    (i == (int'(r_last_gnt) + k) % NUM_SRC)) begin
                    w_found = 1'b1;
                    w_sel   = GID_W'(i);
                end
            end
        end
    end

    // Combinational view of the granted source; the only registered part of the path is the select.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_last  = 1'b0;
        w_src_data  = '0;
        w_src_keep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_src_valid = s_axis_tvalid[i];
                w_src_last  = s_axis_tlast[i];
                w_src_data  = s_axis_tdata[i*64 +: 64];
                w_src_keep  = s_axis_tkeep[i*8 +: 8];
            end
        end
    end

    assign w_beat = (r_state == ST_PASS) && w_src_valid && m_axis_tready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_last_gnt_nxt = r_last_gnt;
        w_grant_id_nxt = r_grant_id;
        w_gap_cnt_nxt  = r_gap_cnt;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        s_axis_tready  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_PASS;
                    w_grant_id_nxt = w_sel;
                    w_last_gnt_nxt = w_sel;
                end
            end
            ST_PASS: begin
                m_axis_tvalid = w_src_valid;
                m_axis_tdata  = w_src_data;
                m_axis_tkeep  = w_src_keep;
                m_axis_tlast  = w_src_last;
                for (int i = 0; i < NUM_SRC; i++) begin
                    s_axis_tready[i] = (r_grant_id == GID_W'(i)) && m_axis_tready;
                end
                if (w_beat && w_src_last) begin
                    if (GAP_CYC == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = 4'(GAP_CYC);
                    end
                end
            end
            ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Mid-frame tkeep must be full; the tlast beat must be an LSB-aligned contiguous mask.
    assign w_keep_err_nxt = w_beat &&
                            (w_src_last ? !keep_is_tail(w_src_keep) : (w_src_keep != 8'hFF));

    always_ff @(posedge tx_clk_out or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= GID_W'(NUM_SRC - 1);
            r_grant_id <= '0;
            r_gap_cnt  <= '0;
            r_keep_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_keep_err <= w_keep_err_nxt;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant_id;
    assign keep_err = r_keep_err;

endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// Directed self-checking bench for axis_tx_pkt_arbiter: a 3-source / 2-gap instance for the main
// scenarios and a 2-source / zero-gap instance for the back-to-back boundary.
module tb_axis_tx_pkt_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    logic [2:0]   tvalid, tlast, tready;
    logic [191:0] tdata;
    logic [23:0]  tkeep;
    logic         mready;
    logic         m_tvalid, m_tlast;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic [1:0]   gid;
    logic         busy, kerr;

    logic [1:0]   b_tvalid, b_tlast, b_tready;
    logic [127:0] b_tdata;
    logic [15:0]  b_tkeep;
    logic         b_mvalid, b_mlast;
    logic [63:0]  b_mdata;
    logic [7:0]   b_mkeep;
    logic [0:0]   b_gid;
    logic         b_busy, b_kerr;

    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;

    axis_tx_pkt_arbiter #(.NUM_SRC(3), .GAP_CYC(2)) dut (
        .tx_clk_out    (clk),
        .sys_rst       (rst),
        .s_axis_tvalid (tvalid),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (mready),
        .grant_id      (gid),
        .busy          (busy),
        .keep_err      (kerr)
    );

    axis_tx_pkt_arbiter #(.NUM_SRC(2), .GAP_CYC(0)) dut_g0 (
        .tx_clk_out    (clk),
        .sys_rst       (rst),
        .s_axis_tvalid (b_tvalid),
        .s_axis_tdata  (b_tdata),
        .s_axis_tkeep  (b_tkeep),
        .s_axis_tlast  (b_tlast),
        .s_axis_tready (b_tready),
        .m_axis_tvalid (b_mvalid),
        .m_axis_tdata  (b_mdata),
        .m_axis_tkeep  (b_mkeep),
        .m_axis_tlast  (b_mlast),
        .m_axis_tready (1'b1),
        .grant_id      (b_gid),
        .busy          (b_busy),
        .keep_err      (b_kerr)
    );

    // Inputs only change #1 after a rising edge, so the negedge view shows what the next edge transfers.
    always @(negedge clk) begin
        if (m_tvalid && mready) n_beats = n_beats + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [63:0] d,
                           input logic [7:0] k, input logic l);
        tvalid[i]         = v;
        tdata[i*64 +: 64] = d;
        tkeep[i*8 +: 8]   = k;
        tlast[i]          = l;
    endtask

    function automatic logic [63:0] rr_word(input int i, input int b);
        return 64'hC0DE_0000_0000_0000 | (64'(i) << 8) | 64'(b);
    endfunction

    logic [63:0] d1 [4] = '{64'h0123_4567_89AB_CDE0, 64'h0123_4567_89AB_CDE1,
                            64'h0123_4567_89AB_CDE2, 64'h0123_4567_89AB_CDE3};
    logic [7:0]  k1 [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
    logic [63:0] d3 [3] = '{64'hB0B0_0000_0000_000A, 64'hB0B0_0000_0000_000B,
                            64'hB0B0_0000_0000_000C};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] exp_rdy;
        int         start;

        rst      = 1'b1;
        tvalid   = 3'b010;
        tdata    = '0;
        tkeep    = '0;
        tlast    = '0;
        mready   = 1'b1;
        b_tvalid = '0;
        b_tlast  = '0;
        b_tdata  = {64'hBEEF_0000_0000_0001, 64'hBEEF_0000_0000_0000};
        b_tkeep  = 16'hFFFF;

        // Reset state, with a request already pending.
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tready",   64'(tready),   64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_kerr",     64'(kerr),     64'd0);
        check("rst_gid",      64'(gid),      64'd0);
        check("rst_m_tdata",  m_tdata,       64'd0);
        tick();
        rst    = 1'b0;
        tvalid = '0;

        // Single source, 4-beat frame, last tkeep 0F.
        set_src(0, 1'b1, d1[0], k1[0], 1'b0);
        @(negedge clk);
        check("t1_arb_busy",  64'(busy),   64'd0);
        check("t1_arb_rdy",   64'(tready), 64'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_src(0, 1'b1, d1[b], k1[b], b == 3);
            @(negedge clk);
            check("t1_valid", 64'(m_tvalid), 64'd1);
            check("t1_data",  m_tdata,       d1[b]);
            check("t1_keep",  64'(m_tkeep),  64'(k1[b]));
            check("t1_last",  64'(m_tlast),  64'(b == 3));
            check("t1_rdy",   64'(tready),   64'd1);
            check("t1_gid",   64'(gid),      64'd0);
            check("t1_busy",  64'(busy),     64'd1);
            tick();
        end
        set_src(0, 1'b0, 64'd0, 8'h00, 1'b0);
        @(negedge clk);
        check("t1_gap1_busy",  64'(busy),     64'd1);
        check("t1_gap1_valid", 64'(m_tvalid), 64'd0);
        check("t1_gap1_kerr",  64'(kerr),     64'd0);
        tick();
        @(negedge clk);
        check("t1_gap2_busy",  64'(busy),     64'd1);
        tick();
        @(negedge clk);
        check("t1_idle_busy",  64'(busy),     64'd0);
        check("t1_idle_gid",   64'(gid),      64'd0);
        tick();

        // Round robin from reset: all three sources request 2-beat frames continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, rr_word(i, 0), 8'hFF, 1'b0);
        for (int f = 0; f < 6; f++) begin
            exp_rdy = 3'b001 << (f % 3);
            @(negedge clk);
            check("rr_idle_busy", 64'(busy), 64'd0);
            tick();
            @(negedge clk);
            check("rr_gid",   64'(gid),    64'(f % 3));
            check("rr_data0", m_tdata,     rr_word(f % 3, 0));
            check("rr_rdy",   64'(tready), 64'(exp_rdy));
            tick();
            set_src(f % 3, 1'b1, rr_word(f % 3, 1), 8'hFF, 1'b1);
            @(negedge clk);
            check("rr_data1", m_tdata,      rr_word(f % 3, 1));
            check("rr_last1", 64'(m_tlast), 64'd1);
            tick();
            set_src(f % 3, 1'b1, rr_word(f % 3, 0), 8'hFF, 1'b0);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check("rr_gap_valid", 64'(m_tvalid), 64'd0);
                check("rr_gap_rdy",   64'(tready),   64'd0);
                tick();
            end
        end
        tvalid = '0;

        // Backpressure 1,0,0,1,1 on a 3-beat frame from source 0 (previous owner was 2).
        start = n_beats;
        set_src(0, 1'b1, d3[0], 8'hFF, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp_c1_data", m_tdata,     d3[0]);
        check("bp_c1_rdy",  64'(tready), 64'd1);
        check("bp_c1_gid",  64'(gid),    64'd0);
        tick();
        set_src(0, 1'b1, d3[1], 8'hFF, 1'b0);
        mready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_stall_data",  m_tdata,       d3[1]);
            check("bp_stall_rdy",   64'(tready),   64'd0);
            check("bp_stall_valid", 64'(m_tvalid), 64'd1);
            tick();
        end
        mready = 1'b1;
        @(negedge clk);
        check("bp_c4_data", m_tdata,     d3[1]);
        check("bp_c4_rdy",  64'(tready), 64'd1);
        tick();
        set_src(0, 1'b1, d3[2], 8'h3F, 1'b1);
        @(negedge clk);
        check("bp_c5_data", m_tdata,      d3[2]);
        check("bp_c5_keep", 64'(m_tkeep), 64'h3F);
        check("bp_c5_last", 64'(m_tlast), 64'd1);
        tick();
        set_src(0, 1'b0, 64'd0, 8'h00, 1'b0);
        @(negedge clk);
        check("bp_beat_count", 64'(n_beats - start), 64'd3);
        check("bp_kerr",       64'(kerr),            64'd0);
        tick();
        tick();

        // Source 1 stalls mid-frame for 5 cycles while sources 0 and 2 request.
        set_src(1, 1'b1, 64'h5151_0000_0000_0000, 8'hFF, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("st_gid",  64'(gid),    64'd1);
        check("st_rdy",  64'(tready), 64'b010);
        tick();
        set_src(1, 1'b0, 64'h5151_0000_0000_0000, 8'hFF, 1'b0);
        set_src(0, 1'b1, 64'h5050_0000_0000_0000, 8'hFF, 1'b1);
        set_src(2, 1'b1, 64'h5252_0000_0000_0000, 8'hFF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("st_hold_gid",   64'(gid),      64'd1);
            check("st_hold_valid", 64'(m_tvalid), 64'd0);
            check("st_hold_rdy",   64'(tready),   64'b010);
            check("st_hold_busy",  64'(busy),     64'd1);
            tick();
        end
        set_src(1, 1'b1, 64'h5151_0000_0000_0001, 8'hFF, 1'b1);
        @(negedge clk);
        check("st_resume_data", m_tdata,      64'h5151_0000_0000_0001);
        check("st_resume_last", 64'(m_tlast), 64'd1);
        tick();
        set_src(1, 1'b0, 64'd0, 8'h00, 1'b0);
        tick();
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        check("st_next_gid",  64'(gid),    64'd2);
        check("st_next_data", m_tdata,     64'h5252_0000_0000_0000);
        check("st_next_rdy",  64'(tready), 64'b100);
        tick();
        set_src(0, 1'b0, 64'd0, 8'h00, 1'b0);
        set_src(2, 1'b0, 64'd0, 8'h00, 1'b0);
        tick();
        tick();

        // Protocol check: 7F on a non-last beat, good middle beat, 05 on the last beat.
        set_src(0, 1'b1, 64'hE0E0_0000_0000_0000, 8'h7F, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("ke_b0_keep", 64'(m_tkeep), 64'h7F);
        check("ke_b0_data", m_tdata,      64'hE0E0_0000_0000_0000);
        check("ke_b0_kerr", 64'(kerr),    64'd0);
        tick();
        set_src(0, 1'b1, 64'hE0E0_0000_0000_0001, 8'hFF, 1'b0);
        @(negedge clk);
        check("ke_pulse1",  64'(kerr),    64'd1);
        check("ke_b1_data", m_tdata,      64'hE0E0_0000_0000_0001);
        tick();
        set_src(0, 1'b1, 64'hE0E0_0000_0000_0002, 8'h05, 1'b1);
        @(negedge clk);
        check("ke_b2_kerr", 64'(kerr),    64'd0);
        check("ke_b2_keep", 64'(m_tkeep), 64'h05);
        check("ke_b2_data", m_tdata,      64'hE0E0_0000_0000_0002);
        tick();
        set_src(0, 1'b0, 64'd0, 8'h00, 1'b0);
        @(negedge clk);
        check("ke_pulse2",  64'(kerr),    64'd1);
        tick();
        @(negedge clk);
        check("ke_gap2",    64'(kerr),    64'd0);
        tick();

        // Reset on beat 2 of a 5-beat frame from source 1; afterwards source 0 must win.
        set_src(1, 1'b1, 64'h6161_0000_0000_0000, 8'hFF, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rm_gid", 64'(gid), 64'd1);
        tick();
        set_src(1, 1'b1, 64'h6161_0000_0000_0001, 8'hFF, 1'b0);
        @(negedge clk);
        check("rm_b2_valid", 64'(m_tvalid), 64'd1);
        #1;
        rst = 1'b1;
        set_src(0, 1'b1, 64'h6060_0000_0000_0000, 8'hFF, 1'b1);
        #1;
        check("rm_async_valid", 64'(m_tvalid), 64'd0);
        check("rm_async_data",  m_tdata,       64'd0);
        check("rm_async_rdy",   64'(tready),   64'd0);
        check("rm_async_busy",  64'(busy),     64'd0);
        check("rm_async_gid",   64'(gid),      64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rm_arb_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check("rm_win_gid",  64'(gid),    64'd0);
        check("rm_win_data", m_tdata,     64'h6060_0000_0000_0000);
        check("rm_win_rdy",  64'(tready), 64'b001);
        tick();
        set_src(0, 1'b0, 64'd0, 8'h00, 1'b0);
        set_src(1, 1'b0, 64'd0, 8'h00, 1'b0);
        tick();
        tick();

        // Zero-gap instance: single-beat frames from both sources back to back.
        b_tvalid = 2'b11;
        b_tlast  = 2'b11;
        @(negedge clk);
        check("g0_arb_busy", 64'(b_busy), 64'd0);
        tick();
        @(negedge clk);
        check("g0_f0_gid",  64'(b_gid),   64'd0);
        check("g0_f0_data", b_mdata,      64'hBEEF_0000_0000_0000);
        check("g0_f0_last", 64'(b_mlast), 64'd1);
        tick();
        @(negedge clk);
        check("g0_idle_busy",  64'(b_busy),   64'd0);
        check("g0_idle_valid", 64'(b_mvalid), 64'd0);
        tick();
        @(negedge clk);
        check("g0_f1_gid",  64'(b_gid),    64'd1);
        check("g0_f1_data", b_mdata,       64'hBEEF_0000_0000_0001);
        check("g0_f1_rdy",  64'(b_tready), 64'b10);
        tick();
        b_tvalid = '0;
        @(negedge clk);
        check("g0_end_busy", 64'(b_busy), 64'd0);
        check("g0_end_kerr", 64'(b_kerr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
